dmem_arbiter: RTL

Two-requester arbiter that shares the single-port data memory (combinational read, clocked write, one address per cycle) between the CPU load/store path and a DMA/block-copy engine. CPU has default priority. A DMA starvation timer and a bounded DMA burst lock guarantee forward progress for both requesters. Sits between both requesters and the memory's WriteEn/DataAddress/DataIn/DataOut pins.

---
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory (combinational read, clocked write)
// between the CPU load/store path and a DMA/block-copy engine. The CPU wins
// by default. Two mechanisms stop either side from being locked out:
//   - a starvation timer that forces DMA ahead of the CPU after MAX_WAIT
//     consecutive denied DMA cycles;
//   - a bounded burst lock that keeps DMA ahead of the CPU for up to
//     LOCK_MAX locked grants, after which the CPU may take one slot.
// Grants are combinational, so every access completes in its grant cycle:
// reads return the same cycle and writes commit at the next posedge.
//
// Optional feature (macro DMEM_ARB_WPROT_EN): DMA writes at or above
// PROT_BASE are acknowledged but suppressed at the memory, and the sticky
// ProtErr flag is raised. Without the macro ProtErr is tied low.
//
// Ports
//   Clk, Reset          clock; synchronous active-high reset
//   CpuReq/We/Addr/WData  CPU access request
//   CpuGnt, CpuRData      CPU access performed this cycle / read data
//   DmaReq/We/Addr/WData  DMA access request
//   DmaLock               keep DMA ownership after this beat (burst)
//   DmaGnt, DmaRData      DMA access performed this cycle / read data
//   MemWriteEn/Address/DataIn  to the memory
//   MemDataOut            from the memory
//   ProtErr               sticky DMA write-protection violation
//
// Burst lock state (lock_r)
//   lock_r | meaning
//   -------+----------------------------------------------------------
//   0      | no burst in progress; CPU has default priority
//   1      | DMA burst in progress; DMA first while lock_cnt < LOCK_MAX
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int W         = 8,
    parameter int A         = 8,
    parameter int MAX_WAIT  = 3,
    parameter int LOCK_MAX  = 4,
    parameter int PROT_BASE = 128
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         CpuReq,
    input  logic         CpuWe,
    input  logic [A-1:0] CpuAddr,
    input  logic [W-1:0] CpuWData,
    output logic         CpuGnt,
    output logic [W-1:0] CpuRData,
    input  logic         DmaReq,
    input  logic         DmaWe,
    input  logic [A-1:0] DmaAddr,
    input  logic [W-1:0] DmaWData,
    input  logic         DmaLock,
    output logic         DmaGnt,
    output logic [W-1:0] DmaRData,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut,
    output logic         ProtErr
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam logic [WCW-1:0] WAIT_TOP = WCW'(MAX_WAIT);
    localparam logic [LCW-1:0] LOCK_TOP = LCW'(LOCK_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t         owner;
    logic           lock_r;
    logic           lock_nxt;
    logic [LCW-1:0] lock_cnt;
    logic [LCW-1:0] lock_cnt_nxt;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_nxt;
    logic           dma_first;
    logic           dma_gnt;
    logic           cpu_gnt;
    logic           dma_wr_blocked;

    // ------------------------------------------------------------------
    // Write protection
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_WPROT_EN
    logic prot_err_r;

    assign dma_wr_blocked = DmaWe && (DmaAddr >= A'(PROT_BASE));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prot_err_r <= 1'b0;
        end else if (dma_gnt && dma_wr_blocked) begin
            prot_err_r <= 1'b1;
        end
    end

    assign ProtErr = prot_err_r;
`else
    logic unused_prot_base;

    assign unused_prot_base = (DmaAddr >= A'(PROT_BASE));
    assign dma_wr_blocked   = 1'b0;
    assign ProtErr          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    // DMA jumps the CPU either inside an unexpired burst or once it has
    // been starved; a starved DMA beats a simultaneous CPU request.
    assign dma_first = (lock_r && (lock_cnt < LOCK_TOP)) || (wait_cnt == WAIT_TOP);

    always_comb begin
        owner = OWN_NONE;
        if (!Reset) begin
            if (DmaReq && dma_first) begin
                owner = OWN_DMA;
            end else if (CpuReq) begin
                owner = OWN_CPU;
            end else if (DmaReq) begin
                owner = OWN_DMA;
            end
        end
    end

    assign cpu_gnt = (owner == OWN_CPU);
    assign dma_gnt = (owner == OWN_DMA);
    assign CpuGnt  = cpu_gnt;
    assign DmaGnt  = dma_gnt;

    // ------------------------------------------------------------------
    // Memory mux; the CPU side is the idle default
    // ------------------------------------------------------------------
    always_comb begin
        MemAddress = CpuAddr;
        MemDataIn  = CpuWData;
        MemWriteEn = 1'b0;
        case (owner)
            OWN_CPU: begin
                MemWriteEn = CpuWe;
            end
            OWN_DMA: begin
                MemAddress = DmaAddr;
                MemDataIn  = DmaWData;
                MemWriteEn = DmaWe && !dma_wr_blocked;
            end
            default: begin
            end
        endcase
    end

    assign CpuRData = MemDataOut;
    assign DmaRData = MemDataOut;

    // ------------------------------------------------------------------
    // Next state for the starvation timer and burst lock
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_nxt = '0;
        lock_nxt     = lock_r;
        lock_cnt_nxt = lock_cnt;

        if (DmaReq && !dma_gnt) begin
            wait_cnt_nxt = (wait_cnt == WAIT_TOP) ? wait_cnt : wait_cnt + 1'b1;
        end

        if (dma_gnt) begin
            lock_nxt = DmaLock;
            if (!DmaLock) begin
                lock_cnt_nxt = '0;
            end else if (lock_r && (lock_cnt != LOCK_TOP)) begin
                lock_cnt_nxt = lock_cnt + 1'b1;
            end
        end else begin
            // The CPU slot after an expired burst restarts the burst budget
            // without ending the burst itself.
            if (cpu_gnt) begin
                lock_cnt_nxt = '0;
            end
            // Requester walked away from its burst.
            if (lock_r && !DmaReq) begin
                lock_nxt     = 1'b0;
                lock_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lock_r   <= 1'b0;
            lock_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            lock_r   <= lock_nxt;
            lock_cnt <= lock_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

endmodule
